video_wr_arbiter: RTL and testbench

- Four-channel write scheduler between the per-channel video sampling buffers and the single DDR AXI write port.
- Picks a ready channel round-robin, issues one fixed-length write burst from that channel's prefetched 256-bit FIFO, and tracks the per-channel write address.
- Keeps a per-channel ping-pong frame buffer select.
- Sits in the DDR clock domain, which is the rd_clk of the sampling blocks.

---
 rtl/video_wr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_video_wr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_arbiter.sv
// Four-channel round-robin write scheduler feeding one AXI write port.
// Issues fixed-length bursts from prefetched channel FIFOs and tracks per-channel ping-pong frame addresses.
`timescale 1ns/1ps
module video_wr_arbiter #(
  parameter int DQ_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 'd32400,
  parameter int FRAME_BYTES = 'h0100_0000,
  parameter int CH_STRIDE   = 'h0200_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                ch_data_ready,
  input  logic [15:0]               ch_trans_id,
  input  logic [3:0]                ch_frame_start,
  input  logic [4*DQ_WIDTH*8-1:0]   ch_rd_data,
  output logic [3:0]                ch_rd_en,
  output logic [ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [3:0]                axi_awid,
  output logic [7:0]                axi_awlen,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [DQ_WIDTH*8-1:0]     axi_wdata,
  output logic                      axi_wvalid,
  output logic                      axi_wlast,
  input  logic                      axi_wready,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic [1:0]                grant,
  output logic                      busy
);

  localparam int BEAT_W = DQ_WIDTH * 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              grant_reg, last_grant_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic [3:0]              awid_reg;
  logic [7:0]              awlen_reg;
  logic [7:0]              beat_cnt_reg;
  logic                    found;
  logic [1:0]              pick, cand;
  logic                    aw_hs, w_hs, b_hs, last_beat;

  logic [15:0]             offset_w [4];
  logic [3:0]              frame_sel_w;
  logic [BEAT_W-1:0]       rd_data_w [4];
  logic [3:0]              trans_id_w [4];

  assign aw_hs     = (state_reg == ADDR) && axi_awready;
  assign w_hs      = (state_reg == DATA) && axi_wready;
  assign b_hs      = (state_reg == RESP) && axi_bvalid;
  assign last_beat = (beat_cnt_reg == 8'(BURST_LEN - 1));

  // First ready channel after the one served last
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_reg + 2'(i);
      if (!found && ch_data_ready[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign awaddr_next = ADDR_WIDTH'(pick) * ADDR_WIDTH'(CH_STRIDE)
                     + (frame_sel_w[pick] ? ADDR_WIDTH'(FRAME_BYTES) : '0)
                     + ADDR_WIDTH'(offset_w[pick]) * ADDR_WIDTH'(DQ_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found)                 state_next = ADDR;
      ADDR:    if (aw_hs)                 state_next = DATA;
      DATA:    if (w_hs && last_beat)     state_next = RESP;
      RESP:    if (b_hs)                  state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_comb begin
    axi_awvalid = (state_reg == ADDR);
    axi_wvalid  = (state_reg == DATA);
    axi_bready  = (state_reg == RESP);
    axi_wlast   = (state_reg == DATA) && last_beat;
    busy        = (state_reg != IDLE);
    axi_wdata   = '0;
    ch_rd_en    = 4'd0;
    if (state_reg == DATA) axi_wdata = rd_data_w[grant_reg];
    if (w_hs) ch_rd_en[grant_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_reg      <= 2'd0;
      last_grant_reg <= 2'd3;
      awaddr_reg     <= '0;
      awid_reg       <= 4'd0;
      awlen_reg      <= 8'd0;
      beat_cnt_reg   <= 8'd0;
    end else begin
      if (state_reg == IDLE && found) begin
        grant_reg  <= pick;
        awaddr_reg <= awaddr_next;
        awid_reg   <= trans_id_w[pick];
        awlen_reg  <= 8'(BURST_LEN - 1);
      end
      if (aw_hs)
        beat_cnt_reg <= 8'd0;
      else if (w_hs)
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
      if (b_hs)
        last_grant_reg <= grant_reg;
    end
  end

  assign axi_awaddr = awaddr_reg;
  assign axi_awid   = awid_reg;
  assign axi_awlen  = awlen_reg;
  assign grant      = grant_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [15:0] offset_reg;
      logic        frame_sel_reg;
      logic        pending_reg;
      logic        owned;
      logic [16:0] sum;

      assign rd_data_w[gi]  = ch_rd_data[gi*BEAT_W +: BEAT_W];
      assign trans_id_w[gi] = ch_trans_id[gi*4 +: 4];
      assign owned          = (state_reg != IDLE) && (grant_reg == 2'(gi));
      assign sum            = {1'b0, offset_reg} + 17'(BURST_LEN);

      // A frame start during our own burst is deferred so the burst lands where it was addressed
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          offset_reg    <= 16'd0;
          frame_sel_reg <= 1'b0;
          pending_reg   <= 1'b0;
        end else if (owned && b_hs) begin
          if (pending_reg || ch_frame_start[gi]) begin
            offset_reg  <= 16'd0;
            pending_reg <= 1'b0;
            if (offset_reg != 16'd0) frame_sel_reg <= ~frame_sel_reg;
          end else if (sum >= 17'(FRAME_BEATS)) begin
            offset_reg    <= 16'd0;
            frame_sel_reg <= ~frame_sel_reg;
          end else begin
            offset_reg <= sum[15:0];
          end
        end else if (ch_frame_start[gi]) begin
          if (owned) begin
            pending_reg <= 1'b1;
          end else begin
            offset_reg <= 16'd0;
            if (offset_reg != 16'd0) frame_sel_reg <= ~frame_sel_reg;
          end
        end
      end

      assign offset_w[gi]    = offset_reg;
      assign frame_sel_w[gi] = frame_sel_reg;
    end
  endgenerate

endmodule

// File: tb/tb_video_wr_arbiter.sv
// Bench for video_wr_arbiter: directed table, frame-start/reset corner cases, long frame wrap and
// randomized handshakes checked against an address/offset model built from the scheduling rules.
`timescale 1ns/1ps
module tb_video_wr_arbiter;
  localparam int     DQ     = 32;
  localparam int     AW     = 28;
  localparam int     BL     = 16;
  localparam int     FB     = 32400;
  localparam longint FBYTES = 64'h0100_0000;
  localparam longint STRIDE = 64'h0200_0000;
  localparam int     BW     = DQ * 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [3:0]         ch_data_ready = 4'd0;
  logic [15:0]        ch_trans_id = 16'd0;
  logic [3:0]         ch_frame_start = 4'd0;
  logic [4*BW-1:0]    ch_rd_data;
  logic [3:0]         ch_rd_en;
  logic [AW-1:0]      axi_awaddr;
  logic [3:0]         axi_awid;
  logic [7:0]         axi_awlen;
  logic               axi_awvalid;
  logic               axi_awready = 1'b0;
  logic [BW-1:0]      axi_wdata;
  logic               axi_wvalid;
  logic               axi_wlast;
  logic               axi_wready = 1'b0;
  logic               axi_bvalid = 1'b0;
  logic               axi_bready;
  logic [1:0]         grant;
  logic               busy;

  always #5 clk = ~clk;

  video_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .ch_data_ready(ch_data_ready), .ch_trans_id(ch_trans_id),
    .ch_frame_start(ch_frame_start), .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .grant(grant), .busy(busy)
  );

  // Channel FIFOs: word content encodes channel and read index
  int fifo_idx [4] = '{0, 0, 0, 0};

  function automatic logic [BW-1:0] pat(input int g, input int idx);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = {8'(g + 1), 24'(idx + k)};
    return v;
  endfunction

  always @(posedge clk)
    for (int g = 0; g < 4; g++)
      if (ch_rd_en[g]) fifo_idx[g] <= fifo_idx[g] + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      assign ch_rd_data[gi*BW +: BW] = pat(gi, fifo_idx[gi]);
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel beat offset, buffer select, last served channel
  int m_off [4];
  int m_sel [4];
  int m_last;
  int exp_idx [4] = '{0, 0, 0, 0};

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      m_off[g] = 0;
      m_sel[g] = 0;
    end
    m_last = 3;
  endtask

  function automatic int pick_ch(input logic [3:0] m);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (m_last + i) % 4;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [AW-1:0] m_addr(input int g);
    longint a;
    a = longint'(g) * STRIDE + longint'(m_sel[g]) * FBYTES + longint'(m_off[g]) * DQ;
    return AW'(a);
  endfunction

  task automatic fs_rule(input int g);
    if (m_off[g] != 0) m_sel[g] = 1 - m_sel[g];
    m_off[g] = 0;
  endtask

  task automatic burst_done(input int g, input bit fs);
    if (fs) fs_rule(g);
    else begin
      m_off[g] = m_off[g] + BL;
      if (m_off[g] >= FB) begin
        m_off[g] = 0;
        m_sel[g] = 1 - m_sel[g];
      end
    end
    m_last = g;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awaddr"},  64'(axi_awaddr),  64'(0));
    chk({tag, "_awid"},    64'(axi_awid),    64'(0));
    chk({tag, "_awlen"},   64'(axi_awlen),   64'(0));
    chk({tag, "_awvalid"}, 64'(axi_awvalid), 64'(0));
    chk({tag, "_wvalid"},  64'(axi_wvalid),  64'(0));
    chk({tag, "_wlast"},   64'(axi_wlast),   64'(0));
    chk({tag, "_bready"},  64'(axi_bready),  64'(0));
    chk({tag, "_grant"},   64'(grant),       64'(0));
    chk({tag, "_busy"},    64'(busy),        64'(0));
    chk({tag, "_rd_en"},   64'(ch_rd_en),    64'(0));
    chk_data({tag, "_wdata"}, axi_wdata, '0);
  endtask

  // One full burst; called and returns at a negedge with the DUT idle.
  // wmode: 0 handshakes always ready, 1 wready toggles 1010, 2 random stalls.
  task automatic do_burst(input logic [3:0] mask, input int ch, input logic [AW-1:0] addr,
                          input logic [3:0] id, input int wmode, input logic [3:0] fs_data,
                          input bit fs_resp);
    int t;
    int beats;
    bit hs;
    bit tog;
    bit fs_done;
    ch_data_ready = mask;
    t = 0;
    while (!axi_awvalid && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!axi_awvalid) begin
      chk("aw_timeout", 64'(0), 64'(1));
      ch_data_ready = 4'd0;
      return;
    end
    chk("aw_latency", 64'(t), 64'(1));
    chk("grant", 64'(grant), 64'(ch));
    chk("awaddr", 64'(axi_awaddr), 64'(addr));
    chk("awid", 64'(axi_awid), 64'(id));
    chk("awlen", 64'(axi_awlen), 64'(BL - 1));
    chk("busy", 64'(busy), 64'(1));
    t = 0;
    do begin
      hs = (wmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
      axi_awready = hs;
      #1;
      chk("awvalid_hold", 64'(axi_awvalid), 64'(1));
      chk("awaddr_hold", 64'(axi_awaddr), 64'(addr));
      @(negedge clk);
      t++;
    end while (!hs && t < 64);
    axi_awready = 1'b0;
    if (!hs) begin
      chk("awready_timeout", 64'(0), 64'(1));
      ch_data_ready = 4'd0;
      return;
    end
    beats = 0; tog = 1'b1; fs_done = 1'b0; t = 0;
    while (beats < BL && t < 256) begin
      case (wmode)
        0:       axi_wready = 1'b1;
        1:       begin axi_wready = tog; tog = !tog; end
        default: axi_wready = ($urandom_range(0, 1) == 1);
      endcase
      if (beats == 3 && !fs_done) begin
        ch_frame_start = fs_data;
        fs_done = 1'b1;
      end else begin
        ch_frame_start = 4'd0;
      end
      #1;
      chk("wvalid", 64'(axi_wvalid), 64'(1));
      chk("rd_en", 64'(ch_rd_en), axi_wready ? 64'(1 << ch) : 64'(0));
      chk("wlast", 64'(axi_wlast), 64'(beats == BL - 1));
      chk_data("wdata", axi_wdata, pat(ch, exp_idx[ch]));
      if (axi_wready) begin
        beats++;
        exp_idx[ch]++;
      end
      @(negedge clk);
      t++;
    end
    axi_wready = 1'b0;
    ch_frame_start = 4'd0;
    if (beats < BL) begin
      chk("data_timeout", 64'(beats), 64'(BL));
      ch_data_ready = 4'd0;
      return;
    end
    t = 0;
    do begin
      hs = (wmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b1;
      axi_bvalid = hs;
      ch_frame_start = (hs && fs_resp) ? 4'(1 << ch) : 4'd0;
      #1;
      chk("bready", 64'(axi_bready), 64'(1));
      chk("wvalid_low", 64'(axi_wvalid), 64'(0));
      @(negedge clk);
      t++;
    end while (!hs && t < 64);
    axi_bvalid = 1'b0;
    ch_frame_start = 4'd0;
    ch_data_ready = 4'd0;
    if (!hs) begin
      chk("bvalid_timeout", 64'(0), 64'(1));
      return;
    end
    #1;
    chk("idle_after_resp", 64'(busy), 64'(0));
    for (int g = 0; g < 4; g++)
      if (g != ch && fs_data[g]) fs_rule(g);
    burst_done(ch, fs_data[ch] || fs_resp);
    $display("burst ch=%0d awaddr=%07h awid=%0h mode=%0d", ch, addr, id, wmode);
  endtask

  typedef struct {
    logic [3:0]    mask;
    logic [15:0]   tid;
    int            g;
    logic [AW-1:0] addr;
    logic [3:0]    id;
    int            wmode;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int t;
    int ch;
    logic [3:0] fsd;
    bit fsr;

    tbl[0] = '{4'b0001, 16'h4321, 0, 28'h000_0000, 4'h1, 0};
    tbl[1] = '{4'b0001, 16'h4321, 0, 28'h000_0200, 4'h1, 0};
    tbl[2] = '{4'b0100, 16'h4321, 2, 28'h400_0000, 4'h3, 1};
    tbl[3] = '{4'b1111, 16'h4321, 3, 28'h600_0000, 4'h4, 0};
    tbl[4] = '{4'b1111, 16'h4321, 0, 28'h000_0400, 4'h1, 0};
    tbl[5] = '{4'b1111, 16'h4321, 1, 28'h200_0000, 4'h2, 0};
    tbl[6] = '{4'b1111, 16'h4321, 2, 28'h400_0200, 4'h3, 0};
    tbl[7] = '{4'b1111, 16'h4321, 3, 28'h600_0200, 4'h4, 0};
    tbl[8] = '{4'b1010, 16'h9F5A, 1, 28'h200_0200, 4'h5, 0};
    tbl[9] = '{4'b1010, 16'h9F5A, 3, 28'h600_0400, 4'h9, 1};

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ch_trans_id = tbl[i].tid;
      do_burst(tbl[i].mask, tbl[i].g, tbl[i].addr, tbl[i].id, tbl[i].wmode, 4'd0, 1'b0);
    end

    // ch0 sits at offset 48: frame start mid-burst is deferred, then the other buffer
    ch_trans_id = 16'h4321;
    do_burst(4'b0001, 0, 28'h000_0600, 4'h1, 0, 4'b0001, 1'b0);
    do_burst(4'b0001, 0, 28'h100_0000, 4'h1, 0, 4'd0, 1'b0);

    // Frame start while idle on ch2 (offset 32)
    ch_frame_start = 4'b0100;
    @(negedge clk);
    ch_frame_start = 4'd0;
    fs_rule(2);
    do_burst(4'b0100, 2, 28'h500_0000, 4'h3, 0, 4'd0, 1'b0);

    // Frame start coinciding with bvalid of ch3 (offset 48)
    do_burst(4'b1000, 3, 28'h600_0600, 4'h4, 0, 4'd0, 1'b1);
    do_burst(4'b1000, 3, 28'h700_0000, 4'h4, 0, 4'd0, 1'b0);

    // Reset during beat 7 of a ch0 burst
    ch_data_ready = 4'b0001;
    t = 0;
    while (!axi_awvalid && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("rst_seq_awvalid", 64'(axi_awvalid), 64'(1));
    axi_awready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0;
    axi_wready = 1'b1;
    repeat (7) @(negedge clk);
    exp_idx[0] += 7;
    #1;
    chk("rst_seq_rd_en", 64'(ch_rd_en), 64'(1));
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    axi_wready = 1'b0;
    ch_data_ready = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_burst(4'b0001, 0, 28'h000_0000, 4'h1, 0, 4'd0, 1'b0);

    // Idle frame start at offset 0 must not flip the buffer
    ch_frame_start = 4'b0100;
    @(negedge clk);
    ch_frame_start = 4'd0;
    fs_rule(2);
    do_burst(4'b0100, 2, 28'h400_0000, 4'h3, 0, 4'd0, 1'b0);

    // Run ch1 through a whole frame: 2025 bursts, then the pong buffer
    for (int k = 0; k < 2025; k++)
      do_burst(4'b0010, 1, m_addr(1), 4'h2, 0, 4'd0, 1'b0);
    do_burst(4'b0010, 1, 28'h300_0000, 4'h2, 0, 4'd0, 1'b0);

    // Randomized masks, stalls, ids and frame starts
    for (int k = 0; k < 200; k++) begin
      ch_trans_id = 16'($urandom);
      ch  = pick_ch(4'($urandom_range(1, 15)));
      fsd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      fsr = ($urandom_range(0, 5) == 0);
      begin
        logic [3:0] mask;
        mask = 4'($urandom_range(1, 15));
        ch = pick_ch(mask);
        do_burst(mask, ch, m_addr(ch), ch_trans_id[ch*4 +: 4], 2, fsd, fsr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
